// File: rtl/test_harness_pkg.sv
// Shared types and constants for the UART loopback harness.
package test_harness_pkg;

  typedef enum logic [1:0] {
    RECEIVE  = 2'd0,
    TRANSMIT = 2'd1
  } state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  localparam logic [1:0] DBG_LAST_RX  = 2'd0;
  localparam logic [1:0] DBG_RX_COUNT = 2'd1;
  localparam logic [1:0] DBG_STATE    = 2'd2;
  localparam logic [1:0] DBG_FRAMING  = 2'd3;

  localparam logic [7:0] NUL = 8'h00;

endpackage

// File: rtl/test_harness_uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, one-cycle valid
// pulse on a good stop bit and a one-cycle framing-error pulse otherwise.
module uart_rx
  import test_harness_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_rx,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_framing_error
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic            r_sync1, r_sync2, r_rx_prev;
  rx_state_t       r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift, r_data;
  logic            r_valid, r_ferr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= i_rx;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
    end
  end

  // Only a true high-to-low edge starts a frame, so a low line left behind
  // by a bad stop bit is not mistaken for a new start bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= RX_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          if (r_rx_prev && !r_sync2) begin
            r_state <= RX_START;
            r_cnt   <= '0;
          end
        end
        RX_START: begin
          if (r_cnt == HALF_LAST) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_state   <= r_sync2 ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        RX_DATA: begin
          if (r_cnt == BIT_LAST) begin
            r_cnt   <= '0;
            r_shift <= {r_sync2, r_shift[7:1]};
            if (r_bit_idx == 3'd7) r_state <= RX_STOP;
            r_bit_idx <= r_bit_idx + 3'd1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        RX_STOP: begin
          if (r_cnt == BIT_LAST) begin
            r_cnt   <= '0;
            r_state <= RX_IDLE;
            if (r_sync2) begin
              r_valid <= 1'b1;
              r_data  <= r_shift;
            end else begin
              r_ferr <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

  assign o_valid         = r_valid;
  assign o_data          = r_data;
  assign o_framing_error = r_ferr;

endmodule

// File: rtl/test_harness.sv
// UART loopback harness: buffers a NUL-terminated (or buffer-filling) message
// and echoes it back, with a button-selected debug value on the LEDs.
module test_harness
  import test_harness_pkg::*;
#(
  parameter int BAUD_RATE       = 115200,
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int BUFFER_DEPTH    = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       uart_receive,
  output logic       uart_transmit,
  input  logic       display_next_debug_value_button,
  output logic [7:0] debug_leds
);

  localparam int CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int ADDR_W = $clog2(BUFFER_DEPTH);
  localparam int CW     = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   CLK_ONE  = CW'(1);
  localparam logic [ADDR_W:0] DEPTH    = (ADDR_W + 1)'(BUFFER_DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);

  logic            w_rx_valid, w_rx_ferr;
  logic [7:0]      w_rx_data;
  logic            w_wr_en, w_bit_end, w_slot_free;
  logic [ADDR_W:0] w_rx_count_inc;

  state_t          r_state;
  logic [ADDR_W:0] r_rx_count, r_tx_count;
  logic [7:0]      r_last_rx, r_rd_data, r_framing_errors, r_leds;
  logic            r_prime, r_busy, r_tx;
  logic [8:0]      r_shift;
  logic [3:0]      r_bit_idx;
  logic [CW-1:0]   r_clk_cnt;
  logic [1:0]      r_btn_sync, r_select;
  logic            r_btn_prev;
  logic [7:0]      r_buffer [BUFFER_DEPTH];

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clock           (clock),
    .reset           (reset),
    .i_rx            (uart_receive),
    .o_valid         (w_rx_valid),
    .o_data          (w_rx_data),
    .o_framing_error (w_rx_ferr)
  );

  assign w_wr_en        = (r_state == RECEIVE) && w_rx_valid;
  assign w_rx_count_inc = r_rx_count + CNT_ONE;
  assign w_bit_end      = r_busy && (r_clk_cnt == BIT_LAST) && (r_bit_idx == 4'd9);
  assign w_slot_free    = !r_busy || w_bit_end;

  always_ff @(posedge clock) begin
    if (w_wr_en) r_buffer[r_rx_count[ADDR_W-1:0]] <= w_rx_data;
    r_rd_data <= r_buffer[r_tx_count[ADDR_W-1:0]];
  end

  // The serialiser advances first; a load or end-of-message in the FSM below
  // overrides it on the stop-bit's last clock so frames stay back-to-back.
  // r_prime spends one clock letting the read register fetch entry 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= RECEIVE;
      r_rx_count <= '0;
      r_tx_count <= '0;
      r_last_rx  <= '0;
      r_prime    <= 1'b0;
      r_busy     <= 1'b0;
      r_tx       <= 1'b1;
      r_shift    <= '1;
      r_bit_idx  <= '0;
      r_clk_cnt  <= '0;
    end else begin
      if (r_busy) begin
        if (r_clk_cnt == BIT_LAST) begin
          r_clk_cnt <= '0;
          r_bit_idx <= r_bit_idx + 4'd1;
          r_tx      <= r_shift[0];
          r_shift   <= {1'b1, r_shift[8:1]};
        end else begin
          r_clk_cnt <= r_clk_cnt + CLK_ONE;
        end
      end
      case (r_state)
        RECEIVE: begin
          if (w_rx_valid) begin
            r_rx_count <= w_rx_count_inc;
            r_last_rx  <= w_rx_data;
            if (w_rx_data == NUL || w_rx_count_inc == DEPTH) begin
              r_state    <= TRANSMIT;
              r_tx_count <= '0;
              r_prime    <= 1'b1;
            end
          end
        end
        TRANSMIT: begin
          if (r_prime) begin
            r_prime <= 1'b0;
          end else if (w_slot_free) begin
            if (r_tx_count != r_rx_count) begin
              r_tx       <= 1'b0;
              r_shift    <= {1'b1, r_rd_data};
              r_bit_idx  <= '0;
              r_clk_cnt  <= '0;
              r_busy     <= 1'b1;
              r_tx_count <= r_tx_count + CNT_ONE;
            end else begin
              r_state    <= RECEIVE;
              r_rx_count <= '0;
              r_busy     <= 1'b0;
              r_tx       <= 1'b1;
            end
          end
        end
        default: r_state <= RECEIVE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_btn_sync       <= '0;
      r_btn_prev       <= 1'b0;
      r_select         <= DBG_LAST_RX;
      r_framing_errors <= '0;
      r_leds           <= '0;
    end else begin
      r_btn_sync <= {r_btn_sync[0], display_next_debug_value_button};
      r_btn_prev <= r_btn_sync[1];
      if (r_btn_sync[1] && !r_btn_prev) r_select <= r_select + 2'd1;
      if (w_rx_ferr && r_framing_errors != 8'hFF)
        r_framing_errors <= r_framing_errors + 8'd1;
      case (r_select)
        DBG_LAST_RX:  r_leds <= r_last_rx;
        DBG_RX_COUNT: r_leds <= 8'(r_rx_count);
        DBG_STATE:    r_leds <= {6'b0, r_state};
        default:      r_leds <= r_framing_errors;
      endcase
    end
  end

  assign uart_transmit = r_tx;
  assign debug_leds    = r_leds;

endmodule

// File: tb/tb_test_harness.sv
// Self-checking bench for test_harness: host-side UART driver, echo monitor
// and a message-level reference model of what must come back.
module tb_test_harness;

  localparam int CPB = 10;

  logic       clock = 1'b0;
  logic       reset;
  logic       uart_receive;
  logic       uart_transmit;
  logic       btn;
  logic [7:0] debug_leds;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_stop_cyc = 0;

  typedef struct {
    logic [7:0] d;
    bit         good;
  } sent_t;

  typedef struct {
    int         presses;
    logic [7:0] exp;
  } dbg_vec_t;

  sent_t      sent_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         st_q[$];

  test_harness #(
    .BAUD_RATE       (10),
    .CLOCK_FREQUENCY (100),
    .BUFFER_DEPTH    (32)
  ) dut (
    .clock                           (clock),
    .reset                           (reset),
    .uart_receive                    (uart_receive),
    .uart_transmit                   (uart_transmit),
    .display_next_debug_value_button (btn),
    .debug_leds                      (debug_leds)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Host-side receiver: every bit must hold its level for all CPB clocks.
  initial begin
    logic       prev;
    int         st;
    logic [9:0] bits;
    bit         ok, abort;
    prev = 1'b1;
    forever begin
      @(negedge clock);
      if (reset && prev && !uart_transmit) begin
        st = cyc; ok = 1; abort = 0; bits = '0;
        for (int b = 0; b < 10; b++) begin
          for (int s = 0; s < CPB; s++) begin
            if (b != 0 || s != 0) @(negedge clock);
            if (!reset) abort = 1;
            if (s == 0) bits[b] = uart_transmit;
            else if (uart_transmit !== bits[b]) ok = 0;
          end
        end
        prev = uart_transmit;
        if (!abort) begin
          check("tx_bit_width", {31'b0, ok}, 32'd1);
          check("tx_stop_bit", {31'b0, bits[9]}, 32'd1);
          rx_q.push_back(bits[8:1]);
          st_q.push_back(st);
        end
      end else begin
        prev = uart_transmit;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_v, input int gap);
    @(negedge clock);
    uart_receive = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      uart_receive = b[i];
      repeat (CPB) @(negedge clock);
    end
    uart_receive = stop_v;
    last_stop_cyc = cyc;
    repeat (CPB) @(negedge clock);
    uart_receive = 1'b1;
    repeat (gap) @(negedge clock);
  endtask

  task automatic tx_byte(input logic [7:0] b, input bit good, input int gap);
    sent_t s;
    s.d = b;
    s.good = good;
    sent_q.push_back(s);
    send_byte(b, good, gap);
  endtask

  task automatic start_msg();
    sent_q = {};
    rx_q   = {};
    st_q   = {};
  endtask

  // Message-level model: drop bad frames, the echo is everything up to and
  // including the first NUL, or the first 32 bytes if no NUL comes first.
  task automatic build_expected();
    exp_q = {};
    foreach (sent_q[i]) begin
      if (!sent_q[i].good) continue;
      exp_q.push_back(sent_q[i].d);
      if (sent_q[i].d == 8'h00 || exp_q.size() == 32) break;
    end
  endtask

  task automatic expect_echo(input string name);
    int n, budget;
    build_expected();
    n = exp_q.size();
    budget = 100 * (n + 2) + 600;
    while (rx_q.size() < n && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    check({name, "_timeout"}, {31'b0, rx_q.size() >= n}, 32'd1);
    repeat (150) @(negedge clock);
    check({name, "_count"}, rx_q.size(), n);
    for (int i = 0; i < n && i < rx_q.size(); i++)
      check({name, "_byte"}, {24'b0, rx_q[i]}, {24'b0, exp_q[i]});
    for (int i = 1; i < st_q.size(); i++)
      check({name, "_back_to_back"}, st_q[i] - st_q[i-1], 32'd100);
    $display("echo %s: sent=%0d expected=%0d received=%0d", name, sent_q.size(), n, rx_q.size());
  endtask

  task automatic press();
    @(negedge clock);
    btn = 1'b1;
    repeat (6) @(negedge clock);
    btn = 1'b0;
    repeat (6) @(negedge clock);
  endtask

  initial begin
    dbg_vec_t dv[5];
    int       lat, w, len;

    dv[0] = '{0, 8'h42};
    dv[1] = '{1, 8'h02};
    dv[2] = '{1, 8'h00};
    dv[3] = '{1, 8'h01};
    dv[4] = '{1, 8'h42};

    reset = 1'b0;
    uart_receive = 1'b1;
    btn = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check("reset_tx", {31'b0, uart_transmit}, 32'd1);
      check("reset_leds", {24'b0, debug_leds}, 32'd0);
    end
    reset = 1'b1;
    repeat (5) @(negedge clock);

    start_msg();
    for (int i = 0; i < 9; i++) tx_byte(8'(8'h41 + i), 1, 0);
    for (int i = 0; i < 3; i++) tx_byte(8'(8'h41 + i), 1, 0);
    for (int i = 0; i < 13; i++) tx_byte(8'(8'h41 + i), 1, 0);
    tx_byte(8'h00, 1, 0);
    lat = last_stop_cyc;
    expect_echo("echo26");
    lat = (st_q.size() > 0) ? st_q[0] - lat : -1;
    check("first_start_latency", {31'b0, (lat >= CPB / 2) && (lat <= CPB / 2 + 8)}, 32'd1);

    start_msg();
    for (int i = 1; i <= 32; i++) tx_byte(8'(i), 1, 0);
    tx_byte(8'h21, 1, 0);
    expect_echo("overflow");

    start_msg();
    tx_byte(8'h55, 0, 20);
    tx_byte(8'h00, 1, 0);
    expect_echo("framing");
    repeat (3) press();
    check("framing_count_leds", {24'b0, debug_leds}, 32'd1);
    press();
    check("select_wrap_leds", {24'b0, debug_leds}, 32'd0);

    start_msg();
    tx_byte(8'h41, 1, 0);
    tx_byte(8'h42, 1, 10);
    for (int i = 0; i < 5; i++) begin
      for (int p = 0; p < dv[i].presses; p++) press();
      repeat (4) @(negedge clock);
      check("debug_vec", {24'b0, debug_leds}, {24'b0, dv[i].exp});
    end
    tx_byte(8'h00, 1, 0);
    expect_echo("debug_flush");

    for (int r = 0; r < 4; r++) begin
      start_msg();
      len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++)
        tx_byte(8'($urandom_range(1, 255)), 1, $urandom_range(0, 15));
      tx_byte(8'h00, 1, $urandom_range(0, 5));
      expect_echo("random");
    end

    start_msg();
    @(negedge clock);
    uart_receive = 1'b0;
    repeat (3) @(negedge clock);
    uart_receive = 1'b1;
    repeat (50) @(negedge clock);
    tx_byte(8'h00, 1, 0);
    expect_echo("glitch");

    start_msg();
    tx_byte(8'h00, 1, 0);
    w = 0;
    while (uart_transmit !== 1'b0 && w < 300) begin
      @(negedge clock);
      w++;
    end
    check("abort_tx_started", {31'b0, uart_transmit}, 32'd0);
    repeat (20) @(negedge clock);
    reset = 1'b0;
    #1;
    check("abort_tx_async", {31'b0, uart_transmit}, 32'd1);
    @(negedge clock);
    check("abort_tx_held", {31'b0, uart_transmit}, 32'd1);
    check("abort_leds", {24'b0, debug_leds}, 32'd0);
    repeat (4) @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    start_msg();
    tx_byte(8'h00, 1, 0);
    expect_echo("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/test_harness.md
Name: test_harness

Overview:
- Board-level UART loopback harness for generated datapaths.
- Receives a NUL-terminated byte string from the host over 8N1 UART and stores it in a 32-byte buffer.
- Once the message is complete, transmits the stored bytes back to the host unchanged, including the terminator.
- Exposes internal status on 8 debug LEDs; a button steps through the available debug values.

Parameters:
- BAUD_RATE, default 115200: UART bit rate in bits/s.
- CLOCK_FREQUENCY, default 100000000: clock rate in Hz. CLKS_PER_BIT = CLOCK_FREQUENCY/BAUD_RATE (integer division); must be >= 4.
- BUFFER_DEPTH, default 32: message buffer size in bytes; power of two.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- uart_receive  input  1  host-to-FPGA serial line; idle high.
- uart_transmit  output  1  FPGA-to-host serial line; idle high.
- display_next_debug_value_button  input  1  asynchronous push button; each press selects the next debug value.
- debug_leds  output  8  currently selected debug value.

Behaviour:
- Reset (reset=0) forces:
  - uart_transmit=1, debug_leds=0, debug select=0.
  - FSM=RECEIVE; rx_count=0, tx_count=0, last_rx_byte=0.
- Input synchronisers: uart_receive and the button each pass through a 2-flop synchroniser; reset value 1 for uart_receive, 0 for the button.
- RX (8N1, LSB first):
  - A falling edge while idle starts a frame.
  - The start bit is re-checked at CLKS_PER_BIT/2; if it reads high, the frame is a glitch and is discarded.
  - Data bits are sampled every CLKS_PER_BIT after that mid-point.
  - The stop bit is sampled; if it reads 0, the byte is dropped (framing error) and framing_errors increments, saturating at 255.
  - On a valid stop bit, a one-cycle rx_valid pulse is issued with rx_data.
- FSM states:
  - RECEIVE:
    - Each rx_valid writes rx_data to buffer[rx_count], rx_count++, last_rx_byte=rx_data.
    - If rx_data==0x00, or rx_count reaches BUFFER_DEPTH after the write, go to TRANSMIT with tx_count=0.
    - When full, any further bytes are ignored until the FSM returns to RECEIVE.
  - TRANSMIT:
    - Send buffer[tx_count] through the TX serialiser, tx_count++, until tx_count==rx_count.
    - Then clear rx_count and return to RECEIVE.
    - rx_valid pulses arriving in this state are discarded.
- TX timing:
  - The first start bit begins within 3 clocks of the terminator's rx_valid.
  - Frame = start(0), 8 data bits LSB first, stop(1); each bit lasts exactly CLKS_PER_BIT clocks.
  - Consecutive bytes are back-to-back: the next start bit immediately follows the previous stop bit.
- Debug:
  - A rising edge on the synchronised button increments select modulo 4. No debounce beyond the synchroniser; the bench drives clean edges.
  - debug_leds mapping (registered, one-cycle latency):
    - 0: last_rx_byte
    - 1: rx_count (zero-extended)
    - 2: {6'b0, FSM state}, where RECEIVE=0, TRANSMIT=1
    - 3: framing_errors
- Reset asserted mid-frame aborts both RX and TX immediately; uart_transmit returns high asynchronously.

Decomposition:
- Package test_harness_pkg holds:
  - FSM state enum (RECEIVE, TRANSMIT).
  - Debug select encodings.
  - NUL terminator constant 8'h00.
- Natural sub-module: uart_rx (synchroniser plus 8N1 deserialiser with valid pulse), parameterised by CLKS_PER_BIT.
- The TX serialiser, buffer and FSM stay in test_harness.

Test Plan:
All scenarios use CLOCK_FREQUENCY=100 and BAUD_RATE=10, so CLKS_PER_BIT=10.
- Reset: hold reset=0 for 20 clocks -> uart_transmit=1 and debug_leds=0 throughout.
- Echo: send the 26-byte string 41..49,41,42,43,41..4D,00 -> the same 26 bytes are received back in order.
  - Each transmitted bit lasts 10 clocks.
  - The first start bit begins within 3 clocks of the terminator's stop-bit sample.
- Overflow: send 32 bytes 0x01..0x20 with no terminator -> transmission starts after the 32nd byte; all 32 bytes are echoed.
  - A 33rd byte sent during transmission does not appear in the echoed output.
- Framing error: send 0x55 with the stop bit forced to 0, then 00 -> only 00 is echoed; with select=3, debug_leds=1.
- Debug cycling: send 41 42 without a terminator, then press the button once per step:
  - select=0 -> debug_leds=0x42
  - select=1 -> debug_leds=0x02
  - select=2 -> debug_leds=0x00
  - a fourth press wraps select back to 0
- Glitch/reset: a 3-clock low pulse on uart_receive produces no byte.
  - Asserting reset during an echo stops TX within 1 clock.
  - A subsequent 00 is echoed as a single byte.
